// File: rtl/axi_acl_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : axi_acl_cfg_ctrl
// Brief    : Shadow/live crossbar access matrix and address windows with a
//            drained atomic commit and a sticky configuration lock.
// Revision : 1.0
// ============================================================================
module axi_acl_cfg_ctrl #(
    parameter int unsigned NB_MANAGER     = 8,
    parameter int unsigned NB_SUBORDINATE = 8,
    parameter int unsigned NB_PRIV_LVL    = 8,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned DRAIN_TIMEOUT  = 1024
) (
    input  logic                                             clk_i,
    input  logic                                             rst_ni,
    input  logic                                             cfg_req_i,
    input  logic                                             cfg_we_i,
    input  logic [11:0]                                      cfg_addr_i,
    input  logic [31:0]                                      cfg_wdata_i,
    input  logic [1:0]                                       cfg_priv_i,
    output logic                                             cfg_gnt_o,
    output logic                                             cfg_rvalid_o,
    output logic [31:0]                                      cfg_rdata_o,
    output logic                                             cfg_err_o,
    input  logic                                             xbar_idle_i,
    output logic                                             xbar_hold_o,
    output logic [NB_SUBORDINATE*NB_MANAGER*NB_PRIV_LVL-1:0] access_ctrl_o,
    output logic [NB_MANAGER*AXI_ADDR_WIDTH-1:0]             start_addr_o,
    output logic [NB_MANAGER*AXI_ADDR_WIDTH-1:0]             end_addr_o
);
    localparam int unsigned      ACC_W       = NB_MANAGER * NB_PRIV_LVL;
    localparam int unsigned      CNT_W       = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DRAIN_TIMEOUT - 1);
    localparam logic [11:0]      ADDR_CTRL   = 12'h000;
    localparam logic [11:0]      ADDR_STATUS = 12'h004;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_APPLY = 2'd2
    } state_e;

    state_e                                   state_q, state_d;
    logic [CNT_W-1:0]                         cnt_q, cnt_d;
    logic [NB_MANAGER-1:0][AXI_ADDR_WIDTH-1:0] sh_start_q, sh_start_d, sh_end_q, sh_end_d;
    logic [NB_MANAGER-1:0][AXI_ADDR_WIDTH-1:0] lv_start_q, lv_start_d, lv_end_q, lv_end_d;
    logic [NB_SUBORDINATE-1:0][ACC_W-1:0]     sh_acc_q, sh_acc_d, lv_acc_q, lv_acc_d;
    logic                                     pending_q, pending_d, locked_q, locked_d;
    logic                                     timeout_q, timeout_d, hold_q, hold_d;
    logic                                     rvalid_q, rvalid_d, err_q, err_d;
    logic [31:0]                              rdata_q, rdata_d;
    logic                                     busy, commit, hit;
    logic [63:0]                              acc_ext, acc_new;

    assign busy      = (state_q != ST_IDLE);
    assign cfg_gnt_o = cfg_req_i & ~(cfg_we_i & busy);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sh_start_d = sh_start_q;
        sh_end_d   = sh_end_q;
        sh_acc_d   = sh_acc_q;
        lv_start_d = lv_start_q;
        lv_end_d   = lv_end_q;
        lv_acc_d   = lv_acc_q;
        pending_d  = pending_q;
        locked_d   = locked_q;
        timeout_d  = timeout_q;
        rvalid_d   = cfg_gnt_o;
        rdata_d    = '0;
        err_d      = 1'b0;
        commit     = 1'b0;
        hit        = 1'b0;
        acc_ext    = '0;
        acc_new    = '0;

        if (cfg_gnt_o && !cfg_we_i) begin
            if (cfg_addr_i == ADDR_CTRL) begin
                hit = 1'b1;
            end else if (cfg_addr_i == ADDR_STATUS) begin
                hit     = 1'b1;
                rdata_d = {28'd0, timeout_q, busy, locked_q, pending_q};
            end
            for (int m = 0; m < NB_MANAGER; m++) begin
                if (cfg_addr_i == 12'h100 + 12'(4 * m)) begin
                    hit     = 1'b1;
                    rdata_d = 32'(sh_start_q[m]);
                end
                if (cfg_addr_i == 12'h180 + 12'(4 * m)) begin
                    hit     = 1'b1;
                    rdata_d = 32'(sh_end_q[m]);
                end
            end
            for (int s = 0; s < NB_SUBORDINATE; s++) begin
                if (cfg_addr_i == 12'h200 + 12'(8 * s)) begin
                    hit     = 1'b1;
                    acc_ext = 64'(sh_acc_q[s]);
                    rdata_d = acc_ext[31:0];
                end
                if (cfg_addr_i == 12'h204 + 12'(8 * s)) begin
                    hit     = 1'b1;
                    acc_ext = 64'(sh_acc_q[s]);
                    rdata_d = acc_ext[63:32];
                end
            end
            err_d = ~hit;
        end else if (cfg_gnt_o) begin
            if (cfg_priv_i != 2'b11) begin
                err_d = 1'b1;
            end else if (cfg_addr_i == ADDR_CTRL) begin
                // Timeout clear stays usable after lock; commit/lock bits do not.
                if (cfg_wdata_i[2]) timeout_d = 1'b0;
                if (locked_q) begin
                    err_d = |cfg_wdata_i[1:0];
                end else begin
                    if (cfg_wdata_i[1]) locked_d = 1'b1;
                    commit = cfg_wdata_i[0];
                end
            end else if (locked_q) begin
                err_d = 1'b1;
            end else begin
                for (int m = 0; m < NB_MANAGER; m++) begin
                    if (cfg_addr_i == 12'h100 + 12'(4 * m)) begin
                        hit           = 1'b1;
                        sh_start_d[m] = cfg_wdata_i[AXI_ADDR_WIDTH-1:0];
                    end
                    if (cfg_addr_i == 12'h180 + 12'(4 * m)) begin
                        hit         = 1'b1;
                        sh_end_d[m] = cfg_wdata_i[AXI_ADDR_WIDTH-1:0];
                    end
                end
                for (int s = 0; s < NB_SUBORDINATE; s++) begin
                    if (cfg_addr_i == 12'h200 + 12'(8 * s)) begin
                        hit         = 1'b1;
                        acc_ext     = 64'(sh_acc_q[s]);
                        acc_new     = {acc_ext[63:32], cfg_wdata_i};
                        sh_acc_d[s] = acc_new[ACC_W-1:0];
                    end
                    if (cfg_addr_i == 12'h204 + 12'(8 * s)) begin
                        hit         = 1'b1;
                        acc_ext     = 64'(sh_acc_q[s]);
                        acc_new     = {cfg_wdata_i, acc_ext[31:0]};
                        sh_acc_d[s] = acc_new[ACC_W-1:0];
                    end
                end
                if (hit) pending_d = 1'b1;
                err_d = ~hit;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (commit) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end
            end
            ST_DRAIN: begin
                if (xbar_idle_i) begin
                    state_d = ST_APPLY;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_APPLY: begin
                lv_start_d = sh_start_q;
                lv_end_d   = sh_end_q;
                lv_acc_d   = sh_acc_q;
                pending_d  = 1'b0;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        hold_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            sh_start_q <= '0;
            sh_end_q   <= '0;
            sh_acc_q   <= '1;
            lv_start_q <= '0;
            lv_end_q   <= '0;
            lv_acc_q   <= '1;
            pending_q  <= 1'b0;
            locked_q   <= 1'b0;
            timeout_q  <= 1'b0;
            hold_q     <= 1'b0;
            rvalid_q   <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sh_start_q <= sh_start_d;
            sh_end_q   <= sh_end_d;
            sh_acc_q   <= sh_acc_d;
            lv_start_q <= lv_start_d;
            lv_end_q   <= lv_end_d;
            lv_acc_q   <= lv_acc_d;
            pending_q  <= pending_d;
            locked_q   <= locked_d;
            timeout_q  <= timeout_d;
            hold_q     <= hold_d;
            rvalid_q   <= rvalid_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
        end
    end

    assign xbar_hold_o   = hold_q;
    assign cfg_rvalid_o  = rvalid_q;
    assign cfg_rdata_o   = rdata_q;
    assign cfg_err_o     = err_q;
    assign access_ctrl_o = lv_acc_q;
    assign start_addr_o  = lv_start_q;
    assign end_addr_o    = lv_end_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_acl_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_acl_cfg_ctrl
// Brief    : Randomized register traffic and commit scenarios for
//            axi_acl_cfg_ctrl, compared against a register-level model.
// Revision : 1.0
// ============================================================================
module tb_axi_acl_cfg_ctrl;
    localparam int NBM  = 8;
    localparam int NBS  = 8;
    localparam int NBP  = 8;
    localparam int AAW  = 32;
    localparam int DT   = 1024;
    localparam int ACCW = NBM * NBP;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    req = 1'b0, we = 1'b0, idle = 1'b1;
    logic [11:0]             addr = '0;
    logic [31:0]             wdata = '0;
    logic [1:0]              priv = '0;
    logic                    gnt, rvalid, err, hold;
    logic [31:0]             rdata;
    logic [NBS*ACCW-1:0]     acc_o;
    logic [NBM*AAW-1:0]      st_o, en_o;

    axi_acl_cfg_ctrl #(
        .NB_MANAGER(NBM), .NB_SUBORDINATE(NBS), .NB_PRIV_LVL(NBP),
        .AXI_ADDR_WIDTH(AAW), .DRAIN_TIMEOUT(DT)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cfg_req_i(req), .cfg_we_i(we), .cfg_addr_i(addr), .cfg_wdata_i(wdata),
        .cfg_priv_i(priv), .cfg_gnt_o(gnt), .cfg_rvalid_o(rvalid),
        .cfg_rdata_o(rdata), .cfg_err_o(err),
        .xbar_idle_i(idle), .xbar_hold_o(hold),
        .access_ctrl_o(acc_o), .start_addr_o(st_o), .end_addr_o(en_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Reference model: shadow and live register files plus status flags.
    logic [31:0] m_start[NBM], m_end[NBM], l_start[NBM], l_end[NBM];
    logic [63:0] m_acc[NBS], l_acc[NBS];
    bit          m_pending, m_locked, m_timeout;
    logic [NBS*ACCW-1:0] e_acc;
    logic [NBM*AAW-1:0]  e_st, e_en;

    function automatic void model_reset();
        for (int i = 0; i < NBM; i++) begin
            m_start[i] = '0; m_end[i] = '0; l_start[i] = '0; l_end[i] = '0;
        end
        for (int i = 0; i < NBS; i++) begin
            m_acc[i] = '1; l_acc[i] = '1;
        end
        m_pending = 0; m_locked = 0; m_timeout = 0;
    endfunction

    function automatic void model_apply();
        for (int i = 0; i < NBM; i++) begin
            l_start[i] = m_start[i]; l_end[i] = m_end[i];
        end
        for (int i = 0; i < NBS; i++) l_acc[i] = m_acc[i];
        m_pending = 0;
    endfunction

    // Returns {err, rdata}.
    function automatic logic [32:0] model_read(input logic [11:0] a, input bit busy);
        int ai = int'(a);
        if (ai % 4 != 0) return {1'b1, 32'd0};
        if (ai == 0) return {1'b0, 32'd0};
        if (ai == 4) return {1'b0, 28'd0, m_timeout, busy, m_locked, m_pending};
        if (ai >= 256 && ai < 256 + 4 * NBM) return {1'b0, m_start[(ai - 256) / 4]};
        if (ai >= 384 && ai < 384 + 4 * NBM) return {1'b0, m_end[(ai - 384) / 4]};
        if (ai >= 512 && ai < 512 + 8 * NBS) begin
            if (ai % 8 == 0) return {1'b0, m_acc[(ai - 512) / 8][31:0]};
            else             return {1'b0, m_acc[(ai - 512) / 8][63:32]};
        end
        return {1'b1, 32'd0};
    endfunction

    // Applies a write to the model and returns the expected err; commit is driven by the test.
    function automatic bit model_write(input logic [11:0] a, input logic [31:0] d, input logic [1:0] p);
        int ai = int'(a);
        if (p != 2'b11) return 1;
        if (ai == 0) begin
            if (d[2]) m_timeout = 0;
            if (m_locked) return (d[1:0] != 2'b00);
            if (d[1]) m_locked = 1;
            return 0;
        end
        if (m_locked) return 1;
        if (ai % 4 != 0) return 1;
        if (ai >= 256 && ai < 256 + 4 * NBM) begin
            m_start[(ai - 256) / 4] = d; m_pending = 1; return 0;
        end
        if (ai >= 384 && ai < 384 + 4 * NBM) begin
            m_end[(ai - 384) / 4] = d; m_pending = 1; return 0;
        end
        if (ai >= 512 && ai < 512 + 8 * NBS) begin
            if (ai % 8 == 0) m_acc[(ai - 512) / 8][31:0]  = d;
            else             m_acc[(ai - 512) / 8][63:32] = d;
            m_pending = 1;
            return 0;
        end
        return 1;
    endfunction

    task automatic build_exp();
        for (int s = 0; s < NBS; s++) e_acc[s*ACCW +: ACCW] = l_acc[s][ACCW-1:0];
        for (int m = 0; m < NBM; m++) begin
            e_st[m*AAW +: AAW] = l_start[m];
            e_en[m*AAW +: AAW] = l_end[m];
        end
    endtask

    // Drives one request; called and returns at posedge+1.
    task automatic cfg_xfer(input logic w, input logic [11:0] a, input logic [31:0] d,
                            input logic [1:0] p, output logic rv, output logic [31:0] rd,
                            output logic e);
        int n = 0;
        req = 1'b1; we = w; addr = a; wdata = d; priv = p;
        #1;
        while (!gnt && n < 5000) begin
            @(posedge clk); #2; n++;
        end
        if (!gnt) begin
            checks++;
            $display("FAIL gnt_timeout addr=%h: gnt=%b required 1", a, gnt);
            req = 1'b0; rv = 1'b0; rd = '0; e = 1'b0;
            @(posedge clk); #1;
            return;
        end
        @(posedge clk); #1;
        req = 1'b0;
        rv = rvalid; rd = rdata; e = err;
    endtask

    task automatic count_hold(output int n);
        n = 0;
        while (hold === 1'b1 && n < 5000) begin
            n++; @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        req = 1'b0; we = 1'b0; idle = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        logic rv, e; logic [31:0] rd;
        do_reset();
        checks++;
        if (acc_o !== '1 || st_o !== '0 || en_o !== '0)
            $display("FAIL reset_live: acc=%h st=%h en=%h required ones/zero/zero", acc_o, st_o, en_o);
        else passes++;
        checks++;
        if ({hold, rvalid, err, rdata} !== 35'd0)
            $display("FAIL reset_outputs: hold=%b rvalid=%b err=%b rdata=%h required all 0", hold, rvalid, err, rdata);
        else passes++;
        cfg_xfer(1'b0, 12'h204, 32'd0, 2'b00, rv, rd, e);
        checks++;
        if ({rv, e, rd} !== {1'b1, 1'b0, 32'hFFFF_FFFF})
            $display("FAIL reset_read_204: rv=%b err=%b rdata=%h required 1 0 ffffffff", rv, e, rd);
        else passes++;
        cfg_xfer(1'b0, 12'h100, 32'd0, 2'b11, rv, rd, e);
        checks++;
        if ({rv, e, rd} !== {1'b1, 1'b0, 32'h0})
            $display("FAIL reset_read_100: rv=%b err=%b rdata=%h required 1 0 00000000", rv, e, rd);
        else passes++;
    endtask

    task automatic test_commit();
        logic rv, e; logic [31:0] rd; logic [32:0] ex; int n;
        cfg_xfer(1'b1, 12'h100, 32'h8000_0000, 2'b11, rv, rd, e);
        ex = {model_write(12'h100, 32'h8000_0000, 2'b11), 32'd0};
        checks++;
        if ({rv, e, rd} !== {1'b1, ex}) $display("FAIL commit_wr: rv=%b err=%b rdata=%h required err=%b", rv, e, rd, ex[32]);
        else passes++;
        cfg_xfer(1'b0, 12'h004, 32'd0, 2'b11, rv, rd, e);
        ex = model_read(12'h004, 0);
        checks++;
        if ({e, rd} !== ex || rd[0] !== 1'b1) $display("FAIL commit_pending: status=%h required %h", rd, ex[31:0]);
        else passes++;
        idle = 1'b1;
        cfg_xfer(1'b1, 12'h000, 32'h1, 2'b11, rv, rd, e);
        void'(model_write(12'h000, 32'h1, 2'b11));
        count_hold(n);
        checks++;
        if (n !== 2) $display("FAIL commit_hold_len: %0d cycles required 2", n);
        else passes++;
        model_apply(); build_exp();
        checks++;
        if (st_o[31:0] !== 32'h8000_0000 || acc_o !== e_acc || st_o !== e_st || en_o !== e_en)
            $display("FAIL commit_live: st=%h required %h", st_o, e_st);
        else passes++;
        cfg_xfer(1'b0, 12'h004, 32'd0, 2'b11, rv, rd, e);
        ex = model_read(12'h004, 0);
        checks++;
        if ({e, rd} !== ex) $display("FAIL commit_pending_clr: status=%h required %h", rd, ex[31:0]);
        else passes++;
    endtask

    task automatic test_timeout();
        logic rv, e; logic [31:0] rd; logic [32:0] ex; logic [31:0] d; int n;
        d = $urandom;
        cfg_xfer(1'b1, 12'h184, d, 2'b11, rv, rd, e);
        void'(model_write(12'h184, d, 2'b11));
        idle = 1'b0;
        cfg_xfer(1'b1, 12'h000, 32'h1, 2'b11, rv, rd, e);
        count_hold(n);
        m_timeout = 1;
        checks++;
        if (n !== DT) $display("FAIL timeout_hold_len: %0d cycles required %0d", n, DT);
        else passes++;
        cfg_xfer(1'b0, 12'h004, 32'd0, 2'b11, rv, rd, e);
        ex = model_read(12'h004, 0);
        checks++;
        if ({e, rd} !== ex) $display("FAIL timeout_status: status=%h required %h", rd, ex[31:0]);
        else passes++;
        build_exp();
        checks++;
        if (acc_o !== e_acc || st_o !== e_st || en_o !== e_en)
            $display("FAIL timeout_live: en=%h required %h", en_o, e_en);
        else passes++;
        cfg_xfer(1'b1, 12'h000, 32'h4, 2'b11, rv, rd, e);
        void'(model_write(12'h000, 32'h4, 2'b11));
        cfg_xfer(1'b0, 12'h004, 32'd0, 2'b11, rv, rd, e);
        ex = model_read(12'h004, 0);
        checks++;
        if ({e, rd} !== ex) $display("FAIL timeout_clear: status=%h required %h", rd, ex[31:0]);
        else passes++;
    endtask

    task automatic test_stall();
        logic rv, e; logic [31:0] rd, a_val, b_val; logic [32:0] ex; int n; bit saw;
        a_val = $urandom; b_val = ~a_val;
        cfg_xfer(1'b1, 12'h104, a_val, 2'b11, rv, rd, e);
        void'(model_write(12'h104, a_val, 2'b11));
        idle = 1'b0;
        cfg_xfer(1'b1, 12'h000, 32'h1, 2'b11, rv, rd, e);
        cfg_xfer(1'b0, 12'h004, 32'd0, 2'b01, rv, rd, e);
        ex = model_read(12'h004, 1);
        checks++;
        if ({rv, e, rd} !== {1'b1, ex}) $display("FAIL stall_read_busy: status=%h required %h", rd, ex[31:0]);
        else passes++;
        model_apply();
        req = 1'b1; we = 1'b1; addr = 12'h104; wdata = b_val; priv = 2'b11;
        #1;
        saw = 0;
        for (int i = 0; i < 5; i++) begin
            if (gnt) saw = 1;
            @(posedge clk); #2;
        end
        checks++;
        if (saw) $display("FAIL stall_gnt_low: gnt=1 during drain required 0");
        else passes++;
        idle = 1'b1;
        n = 0;
        while (!gnt && n < 100) begin
            @(posedge clk); #2; n++;
        end
        checks++;
        if (!gnt || hold !== 1'b0) $display("FAIL stall_gnt_after_idle: gnt=%b hold=%b required 1 0", gnt, hold);
        else passes++;
        @(posedge clk); #1;
        req = 1'b0;
        ex = {model_write(12'h104, b_val, 2'b11), 32'd0};
        checks++;
        if ({rvalid, err, rdata} !== {1'b1, ex}) $display("FAIL stall_resp: rv=%b err=%b required 1 %b", rvalid, err, ex[32]);
        else passes++;
        build_exp();
        checks++;
        if (st_o[63:32] !== a_val || st_o !== e_st) $display("FAIL stall_live: st1=%h required %h", st_o[63:32], a_val);
        else passes++;
    endtask

    task automatic test_random();
        logic rv, e, w; logic [31:0] rd, d; logic [32:0] ex; logic [11:0] a; logic [1:0] p; int n;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) < 7) a = 12'h100 + 12'(4 * $urandom_range(0, 79));
            else                          a = 12'(4 * $urandom_range(0, 1023));
            d = $urandom;
            p = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
            w = 1'($urandom_range(0, 1));
            if (a == 12'h000) w = 1'b0;
            cfg_xfer(w, a, d, p, rv, rd, e);
            if (w) ex = {model_write(a, d, p), 32'd0};
            else   ex = model_read(a, 0);
            checks++;
            if ({rv, e, rd} !== {1'b1, ex})
                $display("FAIL random_%0d we=%b addr=%h priv=%b: rv=%b err=%b rdata=%h required 1 %b %h",
                         i, w, a, p, rv, e, rd, ex[32], ex[31:0]);
            else passes++;
        end
        idle = 1'b1;
        cfg_xfer(1'b1, 12'h000, 32'h1, 2'b11, rv, rd, e);
        count_hold(n);
        model_apply(); build_exp();
        checks++;
        if (n !== 2 || acc_o !== e_acc || st_o !== e_st || en_o !== e_en)
            $display("FAIL random_live: hold=%0d acc=%h required %h", n, acc_o, e_acc);
        else passes++;
    endtask

    task automatic test_priv_lock();
        logic rv, e; logic [31:0] rd, d; logic [32:0] ex; int n;
        d = $urandom;
        cfg_xfer(1'b1, 12'h200, d, 2'b00, rv, rd, e);
        ex = {model_write(12'h200, d, 2'b00), 32'd0};
        checks++;
        if ({rv, e} !== 2'b11) $display("FAIL priv_wr_err: rv=%b err=%b required 1 1", rv, e);
        else passes++;
        cfg_xfer(1'b0, 12'h200, 32'd0, 2'b00, rv, rd, e);
        ex = model_read(12'h200, 0);
        checks++;
        if ({e, rd} !== ex) $display("FAIL priv_unchanged: rdata=%h required %h", rd, ex[31:0]);
        else passes++;
        idle = 1'b1;
        cfg_xfer(1'b1, 12'h000, 32'h3, 2'b11, rv, rd, e);
        ex = {model_write(12'h000, 32'h3, 2'b11), 32'd0};
        count_hold(n);
        model_apply(); build_exp();
        checks++;
        if (e !== ex[32] || n !== 2 || acc_o !== e_acc || st_o !== e_st || en_o !== e_en)
            $display("FAIL lock_commit: err=%b hold=%0d required 0 2", e, n);
        else passes++;
        cfg_xfer(1'b1, 12'h180, d, 2'b11, rv, rd, e);
        ex = {model_write(12'h180, d, 2'b11), 32'd0};
        checks++;
        if ({rv, e} !== {1'b1, ex[32]} || ex[32] !== 1'b1) $display("FAIL lock_wr_err: err=%b required 1", e);
        else passes++;
        cfg_xfer(1'b0, 12'h180, 32'd0, 2'b11, rv, rd, e);
        ex = model_read(12'h180, 0);
        checks++;
        if ({e, rd} !== ex) $display("FAIL lock_unchanged: rdata=%h required %h", rd, ex[31:0]);
        else passes++;
        cfg_xfer(1'b1, 12'h000, 32'h1, 2'b11, rv, rd, e);
        ex = {model_write(12'h000, 32'h1, 2'b11), 32'd0};
        checks++;
        if (e !== ex[32] || hold !== 1'b0) $display("FAIL lock_commit_blocked: err=%b hold=%b required 1 0", e, hold);
        else passes++;
        cfg_xfer(1'b1, 12'h000, 32'h4, 2'b11, rv, rd, e);
        ex = {model_write(12'h000, 32'h4, 2'b11), 32'd0};
        checks++;
        if (e !== ex[32]) $display("FAIL lock_clr_timeout: err=%b required %b", e, ex[32]);
        else passes++;
        cfg_xfer(1'b0, 12'h004, 32'd0, 2'b11, rv, rd, e);
        ex = model_read(12'h004, 0);
        checks++;
        if ({e, rd} !== ex || rd[1] !== 1'b1) $display("FAIL lock_status: status=%h required %h", rd, ex[31:0]);
        else passes++;
        cfg_xfer(1'b0, 12'h0FC, 32'd0, 2'b11, rv, rd, e);
        checks++;
        if ({rv, e, rd} !== {1'b1, 1'b1, 32'd0}) $display("FAIL unmapped_0fc: err=%b rdata=%h required 1 0", e, rd);
        else passes++;
    endtask

    task automatic test_async_reset();
        logic rv, e; logic [31:0] rd;
        do_reset();
        cfg_xfer(1'b1, 12'h100, 32'h1234_5678, 2'b11, rv, rd, e);
        cfg_xfer(1'b1, 12'h200, 32'h0, 2'b11, rv, rd, e);
        idle = 1'b1;
        cfg_xfer(1'b1, 12'h000, 32'h1, 2'b11, rv, rd, e);
        @(posedge clk); #1;
        checks++;
        if (hold !== 1'b1) $display("FAIL arst_in_apply: hold=%b required 1", hold);
        else passes++;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (hold !== 1'b0 || acc_o !== '1 || st_o !== '0 || en_o !== '0 || {rvalid, err, rdata} !== 34'd0)
            $display("FAIL arst_outputs: hold=%b st=%h acc=%h required reset values", hold, st_o, acc_o);
        else passes++;
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        model_reset();
        cfg_xfer(1'b0, 12'h004, 32'd0, 2'b11, rv, rd, e);
        checks++;
        if ({e, rd} !== model_read(12'h004, 0)) $display("FAIL arst_status: status=%h required 0", rd);
        else passes++;
        cfg_xfer(1'b0, 12'h100, 32'd0, 2'b11, rv, rd, e);
        checks++;
        if ({e, rd} !== model_read(12'h100, 0)) $display("FAIL arst_shadow: rdata=%h required 0", rd);
        else passes++;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_commit();
        test_timeout();
        test_stall();
        test_random();
        test_priv_lock();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_acl_cfg_ctrl.md
# axi_acl_cfg_ctrl

Configuration controller for the AXI crossbar's access-control matrix and memory map. Firmware in machine mode programs a shadow copy of the per-subordinate/manager/privilege access table and per-manager address windows over a simple register port. A commit sequence applies the shadow copy atomically: it holds new crossbar traffic, waits for the crossbar to drain, then copies the shadow into the live outputs. A sticky lock bit freezes the configuration until reset.

## Interface
Parameters:
- NB_MANAGER, 8, number of crossbar managers (address windows)
- NB_SUBORDINATE, 8, number of crossbar subordinates
- NB_PRIV_LVL, 8, privilege-level bits per (subordinate, manager) pair; NB_MANAGER*NB_PRIV_LVL <= 64
- AXI_ADDR_WIDTH, 32, window address width (<= 32)
- DRAIN_TIMEOUT, 1024, maximum drain cycles before a commit aborts

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- cfg_req_i  in  1  register access request
- cfg_we_i  in  1  1 = write, 0 = read
- cfg_addr_i  in  12  byte address, word aligned
- cfg_wdata_i  in  32  write data
- cfg_priv_i  in  2  requester privilege (2'b11 = machine)
- cfg_gnt_o  out  1  request accepted this cycle
- cfg_rvalid_o  out  1  response valid
- cfg_rdata_o  out  32  read data
- cfg_err_o  out  1  response error, qualified by cfg_rvalid_o
- xbar_idle_i  in  1  crossbar has no outstanding transactions
- xbar_hold_o  out  1  crossbar must not accept new AW/AR
- access_ctrl_o  out  NB_SUBORDINATE*NB_MANAGER*NB_PRIV_LVL  live access matrix, [s][m][p]
- start_addr_o  out  NB_MANAGER*AXI_ADDR_WIDTH  live window start per manager
- end_addr_o  out  NB_MANAGER*AXI_ADDR_WIDTH  live window end per manager

## Operation
- Register map: 0x000 CTRL (bit0 commit, W1S pulse; bit1 lock, W1S sticky; bit2 clear timeout, W1C pulse). 0x004 STATUS, RO (bit0 pending, bit1 locked, bit2 busy, bit3 timeout). 0x100+4m shadow start[m]. 0x180+4m shadow end[m]. 0x200+8s shadow access[s] bits 31:0; 0x204+8s bits 63:32, with bits above NB_MANAGER*NB_PRIV_LVL read 0 and ignored on write.
- Reads return the shadow copy. Any unmapped address returns rdata 0, err 1.
- A write with cfg_priv_i != 2'b11 is dropped, err 1. Reads are allowed at any privilege.
- Once locked, every write except CTRL bit2 is dropped, err 1. Lock is cleared only by reset.
- A shadow write sets pending. STATUS.pending clears only on APPLY.
- FSM IDLE -> DRAIN on an accepted commit write. DRAIN -> APPLY when xbar_idle_i=1. DRAIN -> IDLE (abort) when the drain counter reaches DRAIN_TIMEOUT-1 without idle; abort sets timeout and leaves shadow and pending unchanged. APPLY -> IDLE after one cycle, copying the full shadow into the live registers.
- xbar_hold_o = 1 in DRAIN and APPLY. busy = state != IDLE.
- A commit with pending=0 still runs the full sequence.
- Commit and lock in the same write: lock takes effect immediately and the commit still runs.
- Reset values: live and shadow access all-ones; start/end all-zero; CTRL/STATUS 0; state IDLE; xbar_hold_o 0; cfg_rvalid_o/cfg_err_o 0; cfg_rdata_o 0.
- Reset asserted mid-commit returns everything to reset values asynchronously.

## Timing
- cfg_gnt_o is combinational. It is 1 with cfg_req_i, except writes while busy, which stall with gnt 0 until IDLE. Reads are never stalled.
- Handshake: the requester holds req/we/addr/wdata stable until gnt. A response comes for every grant: cfg_rvalid_o/rdata/err are registered, 1 cycle after gnt, and rvalid lasts one cycle. Back-to-back grants are supported.
- Commit accepted at cycle t: DRAIN from t+1 with xbar_hold_o high. If xbar_idle_i=1 at t+1, APPLY is at t+2 and new live outputs and hold_o=0 appear at t+3.
- Drain counter starts at 0 on DRAIN entry and increments each DRAIN cycle.

## Test plan
- Reset, then read 0x204 and 0x100: rdata 0xFFFF_FFFF and 0x0000_0000, err 0; access_ctrl_o all ones, xbar_hold_o 0.
- Machine write 0x100 = 0x8000_0000, then commit with xbar_idle_i=1: pending 1 before commit; hold_o high for 2 cycles; start_addr_o[0] = 0x8000_0000 at t+3; pending 0.
- Same commit with xbar_idle_i held 0: hold_o stays high exactly DRAIN_TIMEOUT cycles, then timeout=1, pending=1, live outputs unchanged. Write CTRL bit2 clears timeout.
- Write issued during DRAIN: gnt 0 until IDLE, then accepted; it reaches shadow only and does not affect the in-flight apply.
- Write 0x200 with cfg_priv_i=2'b00: err 1, shadow unchanged. Set lock, then machine write 0x180: err 1; STATUS.locked 1 until rst_ni pulse.
- Read 0x0FC: rdata 0, err 1. Assert rst_ni low during APPLY: all outputs return to reset values immediately.
